// File: rtl/ddr3_burst_writer_pkg.sv
// rtl/ddr3_burst_writer_pkg.sv - MCB instruction codes and burst writer FSM encoding
package ddr3_port_pkg;

   localparam logic [2:0] MCB_WRITE    = 3'b000;
   localparam logic [2:0] MCB_READ     = 3'b001;
   localparam logic [2:0] MCB_WRITE_AP = 3'b010;
   localparam logic [2:0] MCB_READ_AP  = 3'b011;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_FILL = 3'd1;
   localparam logic [2:0] ST_CMD  = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd3;
   localparam logic [2:0] ST_ERR  = 3'd4;

endpackage

// File: rtl/ddr3_burst_writer_if.sv
// rtl/ddr3_burst_writer_if.sv - input word stream plus MCB write-port cmd/wr signals
interface ddr3_burst_writer_if #(
   parameter int ADDR_WIDTH = 30
);
   logic [31:0]           in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  cmd_en;
   logic [2:0]            cmd_instr;
   logic [5:0]            cmd_bl;
   logic [ADDR_WIDTH-1:0] cmd_byte_addr;
   logic                  cmd_full;
   logic                  wr_en;
   logic [3:0]            wr_mask;
   logic [31:0]           wr_data;
   logic                  wr_full;
   logic                  wr_underrun;
   logic                  wr_error;

   modport master (
      input  in_data, in_valid, cmd_full, wr_full, wr_underrun, wr_error,
      output in_ready, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data
   );

   modport slave (
      output in_data, in_valid, cmd_full, wr_full, wr_underrun, wr_error,
      input  in_ready, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data
   );
endinterface

// File: rtl/ddr3_burst_writer.sv
// rtl/ddr3_burst_writer.sv - splits a word transfer into MCB write bursts: fill FIFO, then one command
module ddr3_burst_writer
   import ddr3_port_pkg::*;
#(
   parameter int MAX_BURST   = 64,
   parameter int ADDR_WIDTH  = 30,
   parameter int COUNT_WIDTH = 24
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   calibration_done,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  start_addr,
   input  logic [COUNT_WIDTH-1:0] word_count,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   ddr3_burst_writer_if.master    bus
);

   logic [2:0]             state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
   logic [5:0]             bl_m1_q, bl_m1_d;
   logic [6:0]             fill_cnt_q, fill_cnt_d;
   logic                   error_q, error_d;

   logic [6:0]             burst_len;
   logic [COUNT_WIDTH-1:0] rem_after;
   logic                   err_in, ready, push, cmd_fire;

   // burst length is held as len-1 so cmd_bl resets to 0 and 64 fits in 6 bits
   function automatic logic [5:0] bl_m1_of(input logic [COUNT_WIDTH-1:0] n);
      if (n > COUNT_WIDTH'(MAX_BURST))
         return 6'(MAX_BURST - 1);
      else
         return 6'(n - COUNT_WIDTH'(1));
   endfunction

   assign burst_len = {1'b0, bl_m1_q} + 7'd1;
   assign rem_after = remaining_q - COUNT_WIDTH'(burst_len);
   assign err_in    = bus.wr_underrun | bus.wr_error;
   assign ready     = (state_q == ST_FILL) & (fill_cnt_q < burst_len) & ~bus.wr_full & ~err_in;
   assign push      = ready & bus.in_valid;
   assign cmd_fire  = (state_q == ST_CMD) & ~bus.cmd_full & ~err_in;

   assign bus.in_ready      = ready;
   assign bus.wr_en         = push;
   assign bus.wr_data       = bus.in_data;
   assign bus.wr_mask       = 4'b0000;
   assign bus.cmd_en        = cmd_fire;
   assign bus.cmd_instr     = MCB_WRITE;
   assign bus.cmd_bl        = bl_m1_q;
   assign bus.cmd_byte_addr = addr_q;

   assign busy  = (state_q != ST_IDLE);
   assign done  = (state_q == ST_DONE) | (state_q == ST_ERR);
   assign error = error_q;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      bl_m1_d     = bl_m1_q;
      fill_cnt_d  = fill_cnt_q;
      error_d     = error_q;
      case (state_q)
         ST_IDLE: begin
            if (start && calibration_done) begin
               addr_d      = start_addr & ~ADDR_WIDTH'(3);
               remaining_d = word_count;
               error_d     = 1'b0;
               fill_cnt_d  = 7'd0;
               if (word_count == '0) begin
                  state_d = ST_DONE;
               end else begin
                  bl_m1_d = bl_m1_of(word_count);
                  state_d = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            if (err_in) begin
               error_d = 1'b1;
               state_d = ST_ERR;
            end else if (push) begin
               fill_cnt_d = fill_cnt_q + 7'd1;
               if (fill_cnt_q + 7'd1 == burst_len)
                  state_d = ST_CMD;
            end
         end
         ST_CMD: begin
            if (err_in) begin
               error_d = 1'b1;
               state_d = ST_ERR;
            end else if (cmd_fire) begin
               addr_d      = addr_q + ADDR_WIDTH'({burst_len, 2'b00});
               remaining_d = rem_after;
               if (rem_after == '0) begin
                  state_d = ST_DONE;
               end else begin
                  bl_m1_d    = bl_m1_of(rem_after);
                  fill_cnt_d = 7'd0;
                  state_d    = ST_FILL;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         bl_m1_q     <= '0;
         fill_cnt_q  <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         bl_m1_q     <= bl_m1_d;
         fill_cnt_q  <= fill_cnt_d;
         error_q     <= error_d;
      end
   end

endmodule
